bist_sig_checker: RTL and testbench

Synthesizable response-compaction and verdict stage that sits directly downstream of the circuit under test in the s298 BIST flow. It consumes one CUT output vector per applied test pattern and folds it into a multiple-input signature register (MISR). It counts per-pattern mismatches against an expected response, and at end of test compares the final signature to a golden value. The result is a registered pass/fail verdict, replacing the testbench-only signature bookkeeping with hardware.

---
 rtl/bist_sig_checker_pkg.sv | 23 ++
 rtl/bist_sig_checker_misr.sv | 46 ++++
 rtl/bist_sig_checker.sv | 127 ++++++++++++
 tb/tb_bist_sig_checker.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bist_sig_checker_pkg.sv
// bist_pkg: shared definitions for the s298 BIST response checker.
//   state_t       - verdict FSM states
//   S298_*        - default response width, MISR taps and seed for s298
//   cnt_width()   - counter width able to hold 0..test_count
package bist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int         S298_WIDTH = 6;
  localparam logic [5:0] S298_POLY  = 6'b000010;  // x^6 + x + 1
  localparam logic [5:0] S298_SEED  = 6'b000000;

  // Width needed to count from 0 up to and including test_count.
  function automatic int cnt_width(input int test_count);
    return $clog2(test_count + 1);
  endfunction

endpackage

// File: rtl/bist_sig_checker_misr.sv
// sig_misr_core: multiple-input signature register.
//   clk   - clock, state on rising edge
//   reset - asynchronous active-low reset, loads SEED
//   clear - synchronous reload of SEED
//   en    - fold din into the signature this cycle
//   din   - response vector to compact
//   sig   - current signature (registered)
// The feedback tap set is POLY; bit 0 always receives the MSB.
module sig_misr_core
  import bist_pkg::*;
#(
  parameter int               WIDTH = S298_WIDTH,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(S298_POLY),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(S298_SEED)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] sig
);

  logic [WIDTH-1:0] next_s;

  // Next signature: shift up, fold in the response, feed the MSB back on taps.
  always_comb begin
    next_s    = din ^ {sig[WIDTH-2:0], 1'b0} ^ (POLY & {WIDTH{sig[WIDTH-1]}});
    // bit 0 takes the MSB unconditionally, independent of POLY[0]
    next_s[0] = din[0] ^ sig[WIDTH-1];
  end

  // Signature register with seed reload.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sig <= SEED;
    end else if (clear) begin
      sig <= SEED;
    end else if (en) begin
      sig <= next_s;
    end else begin
      sig <= sig;
    end
  end

endmodule

// File: rtl/bist_sig_checker.sv
// bist_sig_checker: compacts one CUT response per pattern into a MISR,
// counts per-pattern mismatches against the expected response and, at end
// of session, registers a pass/fail verdict against a golden signature.
//   clk, reset            - clock / asynchronous active-low reset
//   start                 - one-cycle pulse, starts a session from IDLE or DONE
//   resp_valid, resp      - one CUT response per valid cycle while running
//   exp_resp              - fault-free response for the same pattern
//   golden                - golden signature, sampled in CHECK
//   busy, done, pass      - session status and verdict (pass valid with done)
//   detected              - at least one mismatching pattern seen
//   signature             - current MISR state
//   err_count             - mismatching patterns (saturating)
//   first_err_idx         - index of first mismatch, all-ones if none
module bist_sig_checker
  import bist_pkg::*;
#(
  parameter int               WIDTH      = S298_WIDTH,
  parameter int               TEST_COUNT = 65,
  parameter logic [WIDTH-1:0] POLY       = WIDTH'(S298_POLY),
  parameter logic [WIDTH-1:0] SEED       = WIDTH'(S298_SEED),
  localparam int              CW         = cnt_width(TEST_COUNT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             resp_valid,
  input  logic [WIDTH-1:0] resp,
  input  logic [WIDTH-1:0] exp_resp,
  input  logic [WIDTH-1:0] golden,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             detected,
  output logic [WIDTH-1:0] signature,
  output logic [CW-1:0]    err_count,
  output logic [CW-1:0]    first_err_idx
);

  localparam logic [CW-1:0] LAST_IDX = CW'(TEST_COUNT - 1);
  localparam logic [CW-1:0] MAX_ERR  = CW'(TEST_COUNT);
  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic [CW-1:0] NO_ERR   = {CW{1'b1}};

  state_t          state_r;
  logic [CW-1:0]   pat_cnt_r;
  logic            launch_s;
  logic            accept_s;
  logic            mismatch_s;

  assign launch_s   = start && ((state_r == IDLE) || (state_r == DONE));
  assign accept_s   = resp_valid && (state_r == RUN);
  assign mismatch_s = (resp != exp_resp);

  sig_misr_core #(
    .WIDTH (WIDTH),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_misr (
    .clk   (clk),
    .reset (reset),
    .clear (launch_s),
    .en    (accept_s),
    .din   (resp),
    .sig   (signature)
  );

  // Session FSM, pattern/error counters and verdict registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= IDLE;
      pat_cnt_r     <= '0;
      err_count     <= '0;
      first_err_idx <= NO_ERR;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      detected      <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            state_r       <= RUN;
            pat_cnt_r     <= '0;
            err_count     <= '0;
            first_err_idx <= NO_ERR;
            busy          <= 1'b1;
            done          <= 1'b0;
            pass          <= 1'b0;
            detected      <= 1'b0;
          end
        end
        RUN: begin
          if (resp_valid) begin
            if (mismatch_s) begin
              if (err_count != MAX_ERR) begin
                err_count <= err_count + ONE;
              end
              // err_count still zero means this is the first mismatch
              if (err_count == '0) begin
                first_err_idx <= pat_cnt_r;
              end
              detected <= 1'b1;
            end
            if (pat_cnt_r == LAST_IDX) begin
              state_r <= CHECK;  // pat_cnt holds at the last index
            end else begin
              pat_cnt_r <= pat_cnt_r + ONE;
            end
          end
        end
        CHECK: begin
          // signature already includes the final response here
          pass    <= (signature == golden);
          done    <= 1'b1;
          busy    <= 1'b0;
          state_r <= DONE;
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bist_sig_checker.sv
// Self-checking bench for bist_sig_checker: a TEST_COUNT=2 instance for the
// hand-written timing sequences and a TEST_COUNT=4 instance for the vector
// table and randomized sessions against a behavioural signature model.
module tb_bist_sig_checker;

  localparam logic [5:0] P = 6'b000010;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // TEST_COUNT = 2 instance
  logic       a_start, a_valid, a_busy, a_done, a_pass, a_det;
  logic [5:0] a_resp, a_exp, a_golden, a_sig;
  logic [1:0] a_err, a_first;

  bist_sig_checker #(.WIDTH(6), .TEST_COUNT(2), .POLY(P), .SEED(6'b000000)) u_tc2 (
    .clk(clk), .reset(reset), .start(a_start), .resp_valid(a_valid),
    .resp(a_resp), .exp_resp(a_exp), .golden(a_golden), .busy(a_busy),
    .done(a_done), .pass(a_pass), .detected(a_det), .signature(a_sig),
    .err_count(a_err), .first_err_idx(a_first));

  // TEST_COUNT = 4 instance
  logic       b_start, b_valid, b_busy, b_done, b_pass, b_det;
  logic [5:0] b_resp, b_exp, b_golden, b_sig;
  logic [2:0] b_err, b_first;

  bist_sig_checker #(.WIDTH(6), .TEST_COUNT(4), .POLY(P), .SEED(6'b000000)) u_tc4 (
    .clk(clk), .reset(reset), .start(b_start), .resp_valid(b_valid),
    .resp(b_resp), .exp_resp(b_exp), .golden(b_golden), .busy(b_busy),
    .done(b_done), .pass(b_pass), .detected(b_det), .signature(b_sig),
    .err_count(b_err), .first_err_idx(b_first));

  typedef struct packed {
    logic [3:0][5:0] resp;    // [i] = pattern i
    logic [3:0][5:0] expr;
    logic [5:0]      golden;
    logic [5:0]      sig;
    logic [2:0]      err;
    logic [2:0]      first;
    logic            pass;
  } vec_t;

  vec_t tbl [4];

  // Signature as polynomial arithmetic: multiply by x modulo the feedback
  // polynomial, then add the response.
  function automatic logic [5:0] misr_ref(input logic [5:0] s, input logic [5:0] r);
    int         v;
    logic [5:0] fb;
    v  = (int'(s) * 2) % 64;
    fb = (s >= 6'd32) ? ((P & 6'b111110) | 6'b000001) : 6'b000000;
    return 6'(v) ^ r ^ fb;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // One TEST_COUNT=4 session; checks the signature after every accept and
  // during bubbles, optionally pulsing start while running.
  task automatic run_b(input logic [3:0][5:0] rs, input logic [3:0][5:0] es,
                       input logic [5:0] g, input int max_gap, input bit poke,
                       output logic [5:0] msig, output int merr, output int mfirst);
    msig   = 6'b000000;
    merr   = 0;
    mfirst = 7;
    b_golden = g;
    b_start  = 1'b1;
    step();
    b_start  = 1'b0;
    chk("b_busy_after_start", b_busy, 1);
    for (int i = 0; i < 4; i++) begin
      int gap;
      gap = (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap));
      for (int k = 0; k < gap; k++) begin
        b_start = poke && ($urandom_range(0, 1) == 0);
        b_resp  = 6'($urandom);
        step();
        b_start = 1'b0;
        chk("b_sig_bubble", b_sig, msig);
      end
      b_valid = 1'b1;
      b_resp  = rs[i];
      b_exp   = es[i];
      step();
      b_valid = 1'b0;
      msig = misr_ref(msig, rs[i]);
      if (rs[i] != es[i]) begin
        if (merr == 0) mfirst = i;
        merr++;
      end
      chk("b_sig_accept", b_sig, msig);
    end
    chk("b_busy_check", b_busy, 1);
    chk("b_done_check", b_done, 0);
    step();
  endtask

  task automatic chk_b_final(input logic [5:0] sig, input int err, input int first, input logic ps);
    chk("b_done", b_done, 1);
    chk("b_busy_done", b_busy, 0);
    chk("b_pass", b_pass, ps);
    chk("b_sig_final", b_sig, sig);
    chk("b_err", b_err, err);
    chk("b_first", b_first, first);
    chk("b_detected", b_det, (err != 0) ? 1 : 0);
  endtask

  task automatic a_session(input logic [5:0] r0, input logic [5:0] r1, input logic [5:0] g,
                           input logic [5:0] s0, input logic [5:0] s1, input logic ps);
    a_golden = g;
    a_start  = 1'b1;
    step();
    a_start  = 1'b0;
    chk("a_busy_start", a_busy, 1);
    chk("a_done_cleared", a_done, 0);
    a_valid = 1'b1;
    a_resp  = r0;
    a_exp   = r0;
    step();
    chk("a_sig_p0", a_sig, s0);
    a_resp = r1;
    a_exp  = r1;
    step();
    a_valid = 1'b0;
    chk("a_sig_p1", a_sig, s1);
    chk("a_busy_check", a_busy, 1);
    chk("a_done_check", a_done, 0);
    step();
    chk("a_done", a_done, 1);
    chk("a_pass", a_pass, ps);
    chk("a_busy_done", a_busy, 0);
    chk("a_err", a_err, 0);
    chk("a_det", a_det, 0);
  endtask

  initial begin
    logic [5:0] ms;
    int         me, mf;

    tbl[0] = '{resp: '0, expr: '0, golden: 6'b000000,
               sig: 6'b000000, err: 3'd0, first: 3'd7, pass: 1'b1};
    tbl[1] = '{resp: {6'd0, 6'd0, 6'd0, 6'd1}, expr: {6'd8, 6'd0, 6'd2, 6'd1},
               golden: 6'b001000, sig: 6'b001000, err: 3'd2, first: 3'd1, pass: 1'b1};
    tbl[2] = '{resp: {6'h3F, 6'h3F, 6'h3F, 6'h3F}, expr: '0, golden: 6'b001011,
               sig: 6'b001010, err: 3'd4, first: 3'd0, pass: 1'b0};
    tbl[3] = '{resp: {6'b010101, 6'b000001, 6'b000000, 6'b100000},
               expr: {6'b010101, 6'b000001, 6'b000000, 6'b100000},
               golden: 6'b011011, sig: 6'b011011, err: 3'd0, first: 3'd7, pass: 1'b1};

    reset   = 1'b0;
    a_start = 1'b0; a_valid = 1'b0; a_resp = '0; a_exp = '0; a_golden = '0;
    b_start = 1'b0; b_valid = 1'b0; b_resp = '0; b_exp = '0; b_golden = '0;
    step();
    step();
    @(negedge clk);
    reset = 1'b1;
    step();

    // reset state
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_pass", a_pass, 0);
    chk("rst_det", a_det, 0);
    chk("rst_sig", a_sig, 6'b000000);
    chk("rst_err", a_err, 0);
    chk("rst_first", a_first, 2'b11);

    // TEST_COUNT=2 sessions: pass, fail, feedback wrap
    a_session(6'b000001, 6'b000000, 6'b000010, 6'b000001, 6'b000010, 1'b1);
    a_valid = 1'b1;
    a_resp  = 6'h3F;
    a_exp   = 6'h00;
    step();
    a_valid = 1'b0;
    chk("a_done_ignores_valid", a_sig, 6'b000010);
    chk("a_done_ignores_err", a_err, 0);
    a_session(6'b000001, 6'b000000, 6'b000011, 6'b000001, 6'b000010, 1'b0);
    a_session(6'b100000, 6'b000000, 6'b000011, 6'b100000, 6'b000011, 1'b1);

    // vector table, back-to-back then with 3-cycle bubbles and start pokes
    for (int t = 0; t < 4; t++) begin
      run_b(tbl[t].resp, tbl[t].expr, tbl[t].golden, 0, 1'b0, ms, me, mf);
      chk_b_final(tbl[t].sig, tbl[t].err, tbl[t].first, tbl[t].pass);
    end
    for (int t = 0; t < 4; t++) begin
      b_golden = tbl[t].golden;
      b_start  = 1'b1;
      step();
      b_start  = 1'b0;
      for (int i = 0; i < 4; i++) begin
        for (int k = 0; k < 3; k++) begin
          b_start = (k == 1);
          step();
          b_start = 1'b0;
        end
        b_valid = 1'b1;
        b_resp  = tbl[t].resp[i];
        b_exp   = tbl[t].expr[i];
        step();
        b_valid = 1'b0;
      end
      step();
      chk_b_final(tbl[t].sig, tbl[t].err, tbl[t].first, tbl[t].pass);
    end

    // abort mid-session with reset
    b_start = 1'b1;
    step();
    b_start = 1'b0;
    b_valid = 1'b1;
    b_resp  = 6'h15;
    b_exp   = 6'h00;
    step();
    b_valid = 1'b0;
    chk("pre_abort_err", b_err, 1);
    reset = 1'b0;
    #2;
    chk("abort_busy", b_busy, 0);
    chk("abort_done", b_done, 0);
    chk("abort_det", b_det, 0);
    chk("abort_sig", b_sig, 6'b000000);
    chk("abort_err", b_err, 0);
    chk("abort_first", b_first, 3'b111);
    @(negedge clk);
    reset = 1'b1;
    step();
    chk("abort_idle", b_busy, 0);
    run_b(tbl[3].resp, tbl[3].expr, tbl[3].golden, 0, 1'b0, ms, me, mf);
    chk_b_final(tbl[3].sig, 0, 7, 1'b1);

    // randomized sessions against the model
    for (int n = 0; n < 40; n++) begin
      logic [3:0][5:0] rs, es;
      logic [5:0]      g, pre;
      for (int i = 0; i < 4; i++) begin
        rs[i] = 6'($urandom);
        es[i] = ($urandom_range(0, 2) == 0) ? 6'($urandom) : rs[i];
      end
      pre = 6'b000000;
      for (int i = 0; i < 4; i++) pre = misr_ref(pre, rs[i]);
      g = ($urandom_range(0, 1) == 0) ? pre : 6'($urandom);
      run_b(rs, es, g, 3, 1'b1, ms, me, mf);
      chk_b_final(ms, me, mf, (g == ms) ? 1'b1 : 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
